life_manager: RTL and testbench

- Gameplay judge that produces the `die` request consumed by the main/gaming state controller, and consumes that controller's `current_state` as `game_state`.
- While gaming, it latches per-pixel collisions within each VGA frame and evaluates them once per frame tick.
- It decrements lives, runs a post-hit invulnerability window, counts survived frames as score, and pulses `die` when the last life is lost.
- It sits between the collision detector and the state controller; score, lives and invuln drive the VGA overlay.

---
 rtl/life_manager_pkg.sv | 18 +
 rtl/life_manager_if.sv | 34 +++
 rtl/life_manager_sat_counter.sv | 34 +++
 rtl/life_manager.sv | 168 ++++++++++++++++
 tb/tb_life_manager.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/life_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_manager_pkg
// Description : Shared encodings for the gameplay judge and state controller.
// Revision    : 1.0 - initial release
// ============================================================================
package life_manager_pkg;

    // Controller state as seen on game_state; shared with the state controller.
    typedef enum logic {
        MAIN   = 1'b0,
        GAMING = 1'b1
    } game_state_e;

    localparam int LIVES_W = 3;

endpackage : life_manager_pkg
`default_nettype wire

// File: rtl/life_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : life_manager_if
// Description : Bundle between game environment and the gameplay judge.
//               master = environment side, slave = life_manager side.
// Revision    : 1.0 - initial release
// ============================================================================
interface life_manager_if
    import life_manager_pkg::*;
#(
    parameter int SCORE_W = 16
) ();

    logic               game_state;
    logic               frame_tick;
    logic               collision;
    logic               die;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] best_score;
    logic               invuln;

    modport master (
        output game_state, frame_tick, collision,
        input  die, lives, score, best_score, invuln
    );

    modport slave (
        input  game_state, frame_tick, collision,
        output die, lives, score, best_score, invuln
    );

endinterface : life_manager_if
`default_nettype wire

// File: rtl/life_manager_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parameterised incrementer that sticks at all-ones,
//               with synchronous clear (clear wins over increment).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up on request, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/life_manager.sv
`default_nettype none
// ============================================================================
// Module      : life_manager
// Description : Gameplay judge. Latches collisions per frame, charges lives,
//               runs the post-hit invulnerability window, scores survived
//               frames, tracks the best score and pulses die on game over.
// Revision    : 1.0 - initial release
// ============================================================================
module life_manager
    import life_manager_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int SCORE_W       = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    life_manager_if.slave    io_lm
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [LIVES_W-1:0] r_lives,     w_lives_nxt;
    logic               r_die,       w_die_nxt;
    logic               r_invuln,    w_invuln_nxt;
    logic               r_hit_latch, w_hit_latch_nxt;
    logic [INV_W-1:0]   r_inv_cnt,   w_inv_cnt_nxt;
    logic [SCORE_W-1:0] r_best;
    logic [SCORE_W-1:0] w_score;
    logic               w_score_clr;
    logic               w_score_inc;
    logic               w_best_upd;
    logic               w_hit;

    // A collision on the tick cycle still belongs to the frame being closed.
    assign w_hit = r_hit_latch | io_lm.collision;

    // Frame score counter; saturates rather than wrapping on very long games.
    sat_counter #(
        .WIDTH   (SCORE_W)
    ) u_score (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_score_clr),
        .i_inc   (w_score_inc),
        .o_count (w_score)
    );

    // State and registered game outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lives     <= '0;
            r_die       <= 1'b0;
            r_invuln    <= 1'b0;
            r_hit_latch <= 1'b0;
            r_inv_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_die       <= w_die_nxt;
            r_invuln    <= w_invuln_nxt;
            r_hit_latch <= w_hit_latch_nxt;
            r_inv_cnt   <= w_inv_cnt_nxt;
        end
    end

    // Next-state and next-output decode; abort (game_state back to MAIN) wins.
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_die_nxt       = 1'b0;
        w_invuln_nxt    = r_invuln;
        w_hit_latch_nxt = r_hit_latch;
        w_inv_cnt_nxt   = r_inv_cnt;
        w_score_clr     = 1'b0;
        w_score_inc     = 1'b0;
        w_best_upd      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (io_lm.game_state == GAMING) begin
                    w_lives_nxt     = LIVES_W'(START_LIVES);
                    w_score_clr     = 1'b1;
                    w_hit_latch_nxt = 1'b0;
                    w_state_nxt     = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (io_lm.game_state == MAIN) begin
                    w_invuln_nxt    = 1'b0;
                    w_lives_nxt     = '0;
                    w_hit_latch_nxt = 1'b0;
                    w_best_upd      = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else if (io_lm.frame_tick) begin
                    w_hit_latch_nxt = 1'b0;
                    if (w_hit && (r_lives <= LIVES_W'(1))) begin
                        w_lives_nxt = '0;
                        w_die_nxt   = 1'b1;
                        w_state_nxt = ST_DEAD;
                    end else if (w_hit) begin
                        w_lives_nxt   = r_lives - LIVES_W'(1);
                        w_inv_cnt_nxt = INV_W'(INVULN_FRAMES);
                        w_invuln_nxt  = 1'b1;
                        w_state_nxt   = ST_INVULN;
                    end else begin
                        w_score_inc = 1'b1;
                    end
                end else if (io_lm.collision) begin
                    w_hit_latch_nxt = 1'b1;
                end
            end

            ST_INVULN: begin
                w_hit_latch_nxt = 1'b0;
                if (io_lm.game_state == MAIN) begin
                    w_invuln_nxt = 1'b0;
                    w_lives_nxt  = '0;
                    w_best_upd   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (io_lm.frame_tick) begin
                    w_score_inc   = 1'b1;
                    w_inv_cnt_nxt = r_inv_cnt - INV_W'(1);
                    if (r_inv_cnt == INV_W'(1)) begin
                        w_invuln_nxt = 1'b0;
                        w_state_nxt  = ST_PLAY;
                    end
                end
            end

            ST_DEAD: begin
                if (io_lm.game_state == MAIN) begin
                    w_best_upd  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Best score is captured whenever a game ends, however it ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= '0;
        end else if (w_best_upd && (w_score > r_best)) begin
            r_best <= w_score;
        end
    end

    assign io_lm.die        = r_die;
    assign io_lm.lives      = r_lives;
    assign io_lm.score      = w_score;
    assign io_lm.best_score = r_best;
    assign io_lm.invuln     = r_invuln;

endmodule : life_manager
`default_nettype wire

// File: tb/tb_life_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_manager
// Description : Directed self-checking bench for life_manager.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_manager;
    import life_manager_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   die_cnt = 0;

    always #5 clk = ~clk;

    life_manager_if #(.SCORE_W(16)) lm ();
    life_manager_if #(.SCORE_W(4))  lm_s ();

    life_manager #(
        .START_LIVES   (3),
        .INVULN_FRAMES (4),
        .SCORE_W       (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_lm (lm)
    );

    // Narrow-score instance, used only to reach the saturation point quickly.
    life_manager #(
        .START_LIVES   (3),
        .INVULN_FRAMES (4),
        .SCORE_W       (4)
    ) dut_s (
        .clk   (clk),
        .rst   (rst),
        .io_lm (lm_s)
    );

    // Count die pulses on the main instance.
    always @(negedge clk) begin
        if (lm.die === 1'b1) die_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_tick(input logic col);
        lm.frame_tick = 1'b1;
        lm.collision  = col;
        step();
        lm.frame_tick = 1'b0;
        lm.collision  = 1'b0;
    endtask

    task automatic col_pulse();
        lm.collision = 1'b1;
        step();
        lm.collision = 1'b0;
    endtask

    initial begin
        lm.game_state   = 1'b0;
        lm.frame_tick   = 1'b0;
        lm.collision    = 1'b0;
        lm_s.game_state = 1'b0;
        lm_s.frame_tick = 1'b0;
        lm_s.collision  = 1'b0;

        idle(2);
        rst = 1'b0;
        step();
        chk("reset_lives", 32'(lm.lives), 32'd0);
        chk("reset_score", 32'(lm.score), 32'd0);

        // Start a game and score one frame, then reset asynchronously mid-cycle.
        lm.game_state = 1'b1;
        step();
        chk("start_lives", 32'(lm.lives), 32'd3);
        do_tick(1'b0);
        chk("pre_rst_score", 32'(lm.score), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lives",  32'(lm.lives),      32'd0);
        chk("async_rst_score",  32'(lm.score),      32'd0);
        chk("async_rst_invuln", 32'(lm.invuln),     32'd0);
        chk("async_rst_die",    32'(lm.die),        32'd0);
        chk("async_rst_best",   32'(lm.best_score), 32'd0);
        lm.game_state = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Fresh game.
        lm.game_state = 1'b1;
        step();
        chk("start2_lives",  32'(lm.lives),  32'd3);
        chk("start2_score",  32'(lm.score),  32'd0);
        chk("start2_invuln", 32'(lm.invuln), 32'd0);

        // Ten clean frames.
        for (int i = 0; i < 10; i++) begin
            idle(2);
            do_tick(1'b0);
        end
        chk("clean_score", 32'(lm.score), 32'd10);
        chk("clean_lives", 32'(lm.lives), 32'd3);
        chk("clean_die",   32'(die_cnt),  32'd0);

        // Non-fatal hit via mid-frame collision pulse.
        idle(1);
        col_pulse();
        idle(1);
        do_tick(1'b0);
        chk("hit1_lives",  32'(lm.lives),  32'd2);
        chk("hit1_invuln", 32'(lm.invuln), 32'd1);
        chk("hit1_score",  32'(lm.score),  32'd10);

        // Collisions throughout the invulnerability window are ignored.
        for (int i = 0; i < 3; i++) begin
            col_pulse();
            do_tick(1'b0);
            chk("inv_invuln", 32'(lm.invuln), 32'd1);
        end
        col_pulse();
        do_tick(1'b1);
        chk("inv_end_invuln", 32'(lm.invuln), 32'd0);
        chk("inv_end_lives",  32'(lm.lives),  32'd2);
        chk("inv_end_score",  32'(lm.score),  32'd14);
        idle(1);
        do_tick(1'b0);
        chk("post_inv_score", 32'(lm.score), 32'd15);
        chk("post_inv_lives", 32'(lm.lives), 32'd2);

        // Collision coincident with the tick counts as a hit.
        do_tick(1'b1);
        chk("coinc_lives",  32'(lm.lives),  32'd1);
        chk("coinc_invuln", 32'(lm.invuln), 32'd1);
        chk("coinc_score",  32'(lm.score),  32'd15);
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        chk("coinc_end_invuln", 32'(lm.invuln), 32'd0);
        chk("coinc_end_score",  32'(lm.score),  32'd19);

        // Fatal hit.
        idle(1);
        col_pulse();
        idle(1);
        do_tick(1'b0);
        chk("fatal_die",   32'(lm.die),   32'd1);
        chk("fatal_lives", 32'(lm.lives), 32'd0);
        step();
        chk("fatal_die_fall", 32'(lm.die), 32'd0);
        for (int i = 0; i < 20; i++) begin
            lm.frame_tick = (i % 4 == 0);
            lm.collision  = (i % 4 == 0);
            step();
        end
        lm.frame_tick = 1'b0;
        lm.collision  = 1'b0;
        chk("dead_die_cnt", 32'(die_cnt),  32'd1);
        chk("dead_score",   32'(lm.score), 32'd19);

        lm.game_state = 1'b0;
        step();
        chk("g1_best",  32'(lm.best_score), 32'd19);
        chk("g1_score", 32'(lm.score),      32'd19);

        // Second game with a lower score, aborted from PLAY.
        lm.game_state = 1'b1;
        step();
        chk("g2_start_score", 32'(lm.score), 32'd0);
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        lm.game_state = 1'b0;
        step();
        chk("g2_score", 32'(lm.score),      32'd3);
        chk("g2_best",  32'(lm.best_score), 32'd19);

        // Third game with a higher score, aborted from INVULN.
        lm.game_state = 1'b1;
        step();
        for (int i = 0; i < 22; i++) do_tick(1'b0);
        do_tick(1'b1);
        chk("g3_invuln", 32'(lm.invuln), 32'd1);
        do_tick(1'b0);
        chk("g3_score", 32'(lm.score), 32'd23);
        lm.game_state = 1'b0;
        step();
        chk("abort_invuln", 32'(lm.invuln),     32'd0);
        chk("abort_lives",  32'(lm.lives),      32'd0);
        chk("abort_die",    32'(die_cnt),       32'd1);
        chk("abort_best",   32'(lm.best_score), 32'd23);
        chk("abort_score",  32'(lm.score),      32'd23);

        // Saturation on the 4-bit score instance.
        lm_s.game_state = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            lm_s.frame_tick = 1'b1;
            step();
        end
        chk("sat_reach", 32'(lm_s.score), 32'd15);
        step();
        step();
        lm_s.frame_tick = 1'b0;
        chk("sat_hold",  32'(lm_s.score), 32'd15);
        chk("sat_lives", 32'(lm_s.lives), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_life_manager
`default_nettype wire
